// File: rtl/ram_b_pkg.sv
// Shared encodings for the RAM-B arbiter: FSM states, access-size codes,
// owner IDs and the RAM address range.
package ram_b_pkg;
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   localparam logic [2:0] SZ_B        = 3'b000;
   localparam logic [2:0] SZ_H        = 3'b001;
   localparam logic [2:0] SZ_W        = 3'b010;
   localparam int         SZ_UNSIGNED = 2;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   localparam int RAM_ADDR_BITS = 7;
endpackage

// File: rtl/ram_b_prio_sel.sv
// Winner select between I and D, with a starvation counter that forces an
// I grant after STARVE_LIMIT back-to-back D grants while I waits.
module ram_b_prio_sel
   import ram_b_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic grant_en,
   input  logic i_req,
   input  logic d_req,
   output logic grant_valid,
   output logic grant_owner
);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_cnt;
   logic             starved;

   assign starved     = i_req && (starve_cnt == LIMIT);
   assign grant_valid = grant_en && (i_req || d_req);
   assign grant_owner = (d_req && !starved) ? OWN_D : OWN_I;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         starve_cnt <= '0;
      end else if (grant_valid) begin
         if ((grant_owner == OWN_D) && i_req) begin
            if (starve_cnt != LIMIT)
               starve_cnt <= starve_cnt + CNT_W'(1);
         end else begin
            starve_cnt <= '0;
         end
      end
   end
endmodule

// File: rtl/ram_b_arbiter.sv
// Shares the single-port data RAM between instruction fetch (I) and
// load/store (D); one access per three cycles with a registered ack.
//
// state  | meaning
// IDLE   | arbitrate; latch the winning request on the edge
// ACCESS | drive RAM from latched request; capture result on the edge
// RESP   | owner's ack high for this cycle only
module ram_b_arbiter
   import ram_b_pkg::*;
#(
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_addr,
   output logic        i_ack,
   output logic [31:0] i_rdata,
   output logic        i_fault,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [2:0]  d_ubhw,
   output logic        d_ack,
   output logic [31:0] d_rdata,
   output logic        d_lfault,
   output logic        d_sfault,
   output logic [31:0] ram_addr,
   output logic [31:0] ram_din,
   output logic        ram_we,
   output logic        ram_re,
   output logic [2:0]  ram_ubhw,
   input  logic [31:0] ram_dout,
   input  logic        ram_lfault,
   input  logic        ram_sfault,
   output logic        busy
);
   state_t      state;
   logic        owner;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_we;
   logic [2:0]  lat_ubhw;
   logic        grant_valid;
   logic        grant_owner;
   logic        in_access;

   ram_b_prio_sel #(
      .STARVE_LIMIT (STARVE_LIMIT),
      .CNT_W        (CNT_W)
   ) u_prio_sel (
      .clk         (clk),
      .rst_n       (rst_n),
      .grant_en    (state == IDLE),
      .i_req       (i_req),
      .d_req       (d_req),
      .grant_valid (grant_valid),
      .grant_owner (grant_owner)
   );

   // Decoded straight from the state register so reset kills the write strobe at once.
   assign in_access = (state == ACCESS);
   assign busy      = (state != IDLE);
   assign ram_we    = in_access && lat_we;
   assign ram_re    = in_access && !lat_we;
   assign ram_addr  = in_access ? lat_addr  : '0;
   assign ram_din   = in_access ? lat_wdata : '0;
   assign ram_ubhw  = in_access ? lat_ubhw  : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         owner     <= OWN_I;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_we    <= 1'b0;
         lat_ubhw  <= '0;
         i_ack     <= 1'b0;
         i_rdata   <= '0;
         i_fault   <= 1'b0;
         d_ack     <= 1'b0;
         d_rdata   <= '0;
         d_lfault  <= 1'b0;
         d_sfault  <= 1'b0;
      end else begin
         i_ack <= 1'b0;
         d_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_valid) begin
                  owner <= grant_owner;
                  if (grant_owner == OWN_D) begin
                     lat_addr  <= d_addr;
                     lat_we    <= d_we;
                     lat_wdata <= d_wdata;
                     lat_ubhw  <= d_ubhw;
                  end else begin
                     lat_addr  <= i_addr;
                     lat_we    <= 1'b0;
                     lat_wdata <= '0;
                     lat_ubhw  <= SZ_W;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (owner == OWN_I) begin
                  i_rdata <= ram_lfault ? 32'h0 : ram_dout;
                  i_fault <= ram_lfault;
                  i_ack   <= 1'b1;
               end else begin
                  if (!lat_we)
                     d_rdata <= ram_lfault ? 32'h0 : ram_dout;
                  d_lfault <= ram_lfault;
                  d_sfault <= ram_sfault;
                  d_ack    <= 1'b1;
               end
               state <= RESP;
            end
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
